// File: rtl/toaplan2_cen_bank_if.sv
// Configuration, pause and enable-output bundle for the fractional clock-enable bank.
// Latency: none (wiring only).
// Backpressure: none; the bank consumes writes and emits enables every CLK.
interface toaplan2_cen_bank_if #(
  parameter int NCH = 8,
  parameter int WN  = 10,
  parameter int WD  = 12
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic [WN-1:0]  cfg_num;
  logic [WD-1:0]  cfg_den;
  logic           cfg_force;
  logic           cfg_err;
  logic           pause;
  logic [NCH-1:0] pause_mask;
  logic [NCH-1:0] cen;
  logic [NCH-1:0] cenb;
  logic [NCH-1:0] pend;

  modport master (
    output cfg_we, cfg_ch, cfg_num, cfg_den, cfg_force, pause, pause_mask,
    input  cfg_err, cen, cenb, pend
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_num, cfg_den, cfg_force, pause, pause_mask,
    output cfg_err, cen, cenb, pend
  );
endinterface

// File: rtl/toaplan2_cen_bank.sv
// Bank of NCH fractional clock-enable generators (CEN at CLK*NUM/DEN, CENB at half period).
// Latency: CEN/CENB/PEND/CFG_ERR are registered, 1 CLK after the deciding cycle.
// Backpressure: none; PAUSE & PAUSE_MASK freezes a channel's accumulator and silences it.
module toaplan2_cen_bank #(
  parameter int NCH = 8,
  parameter int WN  = 10,
  parameter int WD  = 12,
  parameter logic [NCH*WN-1:0] DEF_NUM = {NCH{WN'(1)}},
  parameter logic [NCH*WD-1:0] DEF_DEN = {NCH{WD'(8)}}
) (
  input logic                 clk_i,
  input logic                 rst_i,
  toaplan2_cen_bank_if.slave  bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW:0] NCH_LIM = (CW+1)'(NCH);

  // Per-channel state: accumulator, active rate, shadow rate.
  logic [WD-1:0]  acc_q     [NCH];
  logic [WD-1:0]  acc_d     [NCH];
  logic [WN-1:0]  num_q     [NCH];
  logic [WN-1:0]  num_d     [NCH];
  logic [WD-1:0]  den_q     [NCH];
  logic [WD-1:0]  den_d     [NCH];
  logic [WN-1:0]  shd_num_q [NCH];
  logic [WN-1:0]  shd_num_d [NCH];
  logic [WD-1:0]  shd_den_q [NCH];
  logic [WD-1:0]  shd_den_d [NCH];
  logic [NCH-1:0] cen_q, cen_d, cenb_q, cenb_d, pend_q, pend_d;
  logic           err_q, err_d;

  // Per-channel combinational terms.
  logic [WD:0]    sum  [NCH];
  logic [WD-1:0]  half [NCH];
  logic [NCH-1:0] wrap, held, wr_hit;

  // Write validation: nonzero DEN, step no larger than half of DEN, channel in range.
  logic [WD:0] num2x;
  logic        cfg_ok;
  assign num2x  = (WD+1)'(bus.cfg_num) << 1;
  assign cfg_ok = (bus.cfg_den != '0) &&
                  (num2x <= {1'b0, bus.cfg_den}) &&
                  ({1'b0, bus.cfg_ch} < NCH_LIM);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign sum[g]    = {1'b0, acc_q[g]} + (WD+1)'(num_q[g]);
    assign half[g]   = den_q[g] >> 1;
    assign wrap[g]   = sum[g] >= {1'b0, den_q[g]};
    assign held[g]   = bus.pause & bus.pause_mask[g];
    assign wr_hit[g] = bus.cfg_we & cfg_ok & (bus.cfg_ch == CW'(g));
  end

  // Next-state: forced writes win; otherwise accumulate, apply shadow at wrap, capture writes.
  always_comb begin
    acc_d     = acc_q;
    num_d     = num_q;
    den_d     = den_q;
    shd_num_d = shd_num_q;
    shd_den_d = shd_den_q;
    pend_d    = pend_q;
    cen_d     = '0;
    cenb_d    = '0;
    err_d     = bus.cfg_we & ~cfg_ok;
    for (int i = 0; i < NCH; i++) begin
      if (wr_hit[i] && bus.cfg_force) begin
        num_d[i]     = bus.cfg_num;
        den_d[i]     = bus.cfg_den;
        shd_num_d[i] = bus.cfg_num;
        shd_den_d[i] = bus.cfg_den;
        acc_d[i]     = '0;
        pend_d[i]    = 1'b0;
      end else begin
        if (!held[i]) begin
          if (wrap[i]) begin
            // sum < 2*DEN, so the WD-bit difference is exact.
            acc_d[i] = sum[i][WD-1:0] - den_q[i];
            cen_d[i] = 1'b1;
          end else begin
            acc_d[i]  = sum[i][WD-1:0];
            cenb_d[i] = (acc_q[i] < half[i]) && (sum[i] >= {1'b0, half[i]});
          end
        end
        // Shadow goes live at a period boundary, or immediately on a stopped channel.
        if (pend_q[i] && ((!held[i] && wrap[i]) || (num_q[i] == '0))) begin
          num_d[i]  = shd_num_q[i];
          den_d[i]  = shd_den_q[i];
          pend_d[i] = 1'b0;
          // A stopped channel may hold an acc beyond the new DEN; restart its period.
          if ((num_q[i] == '0) && (acc_q[i] >= shd_den_q[i])) begin
            acc_d[i] = '0;
          end
        end
        // A write coinciding with a wrap waits in the shadow for the next wrap.
        if (wr_hit[i]) begin
          shd_num_d[i] = bus.cfg_num;
          shd_den_d[i] = bus.cfg_den;
          pend_d[i]    = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset to the default rates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]     <= '0;
        num_q[i]     <= DEF_NUM[i*WN +: WN];
        den_q[i]     <= DEF_DEN[i*WD +: WD];
        shd_num_q[i] <= DEF_NUM[i*WN +: WN];
        shd_den_q[i] <= DEF_DEN[i*WD +: WD];
      end
      cen_q  <= '0;
      cenb_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      num_q     <= num_d;
      den_q     <= den_d;
      shd_num_q <= shd_num_d;
      shd_den_q <= shd_den_d;
      cen_q     <= cen_d;
      cenb_q    <= cenb_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign bus.cen     = cen_q;
  assign bus.cenb    = cenb_q;
  assign bus.pend    = pend_q;
  assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_toaplan2_cen_bank.sv
// Directed bench for the clock-enable bank: six channels, ch0 at 1/4, ch1 at 9/64, rest 1/8.
// Outputs are sampled 1 time unit after each rising edge.
// t counts rising edges since reset release.
module tb_toaplan2_cen_bank;
  localparam int NCH = 6;
  localparam int WN  = 10;
  localparam int WD  = 12;
  localparam logic [NCH*WN-1:0] TB_NUM = {10'd1, 10'd1, 10'd1, 10'd1, 10'd9, 10'd1};
  localparam logic [NCH*WD-1:0] TB_DEN = {12'd8, 12'd8, 12'd8, 12'd8, 12'd64, 12'd4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   t = 0;

  always #5 clk = ~clk;

  toaplan2_cen_bank_if #(.NCH(NCH), .WN(WN), .WD(WD)) bus ();

  toaplan2_cen_bank #(
    .NCH(NCH), .WN(WN), .WD(WD), .DEF_NUM(TB_NUM), .DEF_DEN(TB_DEN)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chkv(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) t++;
  endtask

  task automatic cfg(input int ch, input int num, input int den, input logic frc);
    bus.cfg_ch    = 3'(ch);
    bus.cfg_num   = 10'(num);
    bus.cfg_den   = 12'(den);
    bus.cfg_force = frc;
    bus.cfg_we    = 1'b1;
  endtask

  task automatic cfg_off();
    bus.cfg_we    = 1'b0;
    bus.cfg_force = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt1, last1, gap_bad, both_bad;
    int wch [4];
    int wnum[4];
    int wden[4];
    logic werr[4];
    wch  = '{0, 0, 6, 4};
    wnum = '{1, 3, 1, 2};
    wden = '{0, 5, 8, 4};
    werr = '{1'b1, 1'b1, 1'b1, 1'b0};
    cnt1 = 0; last1 = 0; gap_bad = 0; both_bad = 0;

    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_num = '0; bus.cfg_den = '0;
    bus.cfg_force = 1'b0; bus.pause = 1'b0; bus.pause_mask = '0;

    // Reset state.
    step(); step();
    chkv("rst_cen",  int'(bus.cen), 0);
    chkv("rst_cenb", int'(bus.cenb), 0);
    chkv("rst_pend", int'(bus.pend), 0);
    chk1("rst_err",  bus.cfg_err, 1'b0);
    rst = 1'b0;

    // Free run: ch0 1/4 and ch2 1/8 phase, ch1 9/64 over 6400 CLK.
    for (int k = 0; k < 6400; k++) begin
      step();
      if (t <= 16) begin
        chk1("t1_cen0",  bus.cen[0],  t % 4 == 0);
        chk1("t1_cenb0", bus.cenb[0], t % 4 == 2);
        chk1("t1_cen2",  bus.cen[2],  t % 8 == 0);
        chk1("t1_cenb2", bus.cenb[2], t % 8 == 4);
      end
      if ((bus.cen & bus.cenb) != '0) both_bad++;
      if (bus.cen[1]) begin
        cnt1++;
        if (last1 != 0 && (t - last1) != 7 && (t - last1) != 8) gap_bad++;
        last1 = t;
      end
    end
    chkv("t2_count", cnt1, 900);
    chkv("t2_gaps", gap_bad, 0);
    chkv("cen_cenb_overlap", both_bad, 0);

    // Shadow write to ch2 (1/8 -> 1/4) three CLKs into its period.
    for (int k = 0; k < 8 && (t % 8) != 3; k++) step();
    cfg(2, 1, 4, 1'b0);
    step();
    cfg_off();
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) step();
      chk1("t3_pend2", bus.pend[2], j < 4);
      chk1("t3_cen2",  bus.cen[2],  j >= 4 && (j - 4) % 4 == 0);
      chk1("t3_cenb2", bus.cenb[2], j == 0 || (j >= 4 && (j - 4) % 4 == 2));
    end

    // Rejected writes (DEN=0, 2*NUM>DEN, channel out of range) and a boundary-legal one.
    for (int i = 0; i < 4; i++) begin
      cfg(wch[i], wnum[i], wden[i], 1'b0);
      step();
      cfg_off();
      chk1("t4_err",  bus.cfg_err, werr[i]);
      chk1("t4_cen0", bus.cen[0], t % 4 == 0);
      chkv("t4_pend", int'(bus.pend), werr[i] ? 0 : 32'h10);
      step();
      chk1("t4_err_clr", bus.cfg_err, 1'b0);
      chk1("t4_cen0b", bus.cen[0], t % 4 == 0);
    end

    // Pause ch0 for 20 CLK one CLK into its period; ch5 keeps running.
    for (int k = 0; k < 4 && (t % 4) != 1; k++) step();
    bus.pause = 1'b1;
    bus.pause_mask = 6'h01;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk1("t5_cen0_held",  bus.cen[0], 1'b0);
      chk1("t5_cenb0_held", bus.cenb[0], 1'b0);
      chk1("t5_cen5_free",  bus.cen[5], t % 8 == 0);
    end
    bus.pause = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk1("t5_cenb0_rel", bus.cenb[0], k == 1);
      chk1("t5_cen0_rel",  bus.cen[0],  k == 3);
    end

    // Forced 1/2 write to ch3 at acc=7, where the old rate would have wrapped.
    for (int k = 0; k < 8 && (t % 8) != 7; k++) step();
    cfg(3, 1, 2, 1'b1);
    step();
    cfg_off();
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) step();
      if (j == 0) chk1("t6_pend3", bus.pend[3], 1'b0);
      chk1("t6_cen3",  bus.cen[3],  j >= 2 && j % 2 == 0);
      chk1("t6_cenb3", bus.cenb[3], j >= 1 && j % 2 == 1);
    end

    // Stop ch2 with NUM=0, then a shadow write applies on the very next CLK.
    cfg(2, 0, 4, 1'b1);
    step();
    cfg_off();
    for (int k = 1; k <= 8; k++) begin
      step();
      chkv("stop_pulses2", int'({bus.cen[2], bus.cenb[2]}), 0);
    end
    cfg(2, 1, 4, 1'b0);
    step();
    cfg_off();
    chk1("stop_pend_set", bus.pend[2], 1'b1);
    step();
    chk1("stop_pend_clr", bus.pend[2], 1'b0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk1("stop_cen2",  bus.cen[2],  k == 5);
      chk1("stop_cenb2", bus.cenb[2], k == 3);
    end

    // Reset while ch5 has a pending shadow: PEND drops and defaults return.
    cfg(5, 1, 2, 1'b0);
    step();
    cfg_off();
    chk1("t6_pend5", bus.pend[5], 1'b1);
    rst = 1'b1;
    step();
    chkv("rst2_pend", int'(bus.pend), 0);
    chkv("rst2_cen",  int'(bus.cen), 0);
    chkv("rst2_cenb", int'(bus.cenb), 0);
    rst = 1'b0;
    t = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk1("rst2_cen0",  bus.cen[0],  t % 4 == 0);
      chk1("rst2_cen3",  bus.cen[3],  t % 8 == 0);
      chk1("rst2_cenb3", bus.cenb[3], t % 8 == 4);
      chk1("rst2_cen4",  bus.cen[4],  t % 8 == 0);
      chk1("rst2_cen5",  bus.cen[5],  t % 8 == 0);
    end
    chkv("rst2_pend_end", int'(bus.pend), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
